em_job_arbiter: RTL and testbench

Round-robin job arbiter that shares one energy monitor among NUM_REQ requesters (e.g. parallel annealer lanes). It grants one requester at a time and forwards its spin vector to the monitor's spin channel. It then captures the resulting energy in a local register and returns it to the granted requester. The grant is held until that return handshake completes. It sits between the requester lanes and the energy monitor's spin/energy handshake ports.

---
 rtl/em_job_arbiter.sv | 128 ++++++++++++
 tb/tb_em_job_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/em_job_arbiter.sv
// Round-robin arbiter sharing one energy monitor among NUM_REQ requesters.
// One job in flight at a time: grant, forward spin, capture energy, return it.
module em_job_arbiter #(
  parameter  int NUM_REQ  = 4,
  parameter  int SPIN_W   = 256,
  parameter  int ENERGY_W = 32,
  localparam int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              en_i,
  input  logic [NUM_REQ-1:0]                req_spin_valid_i,
  input  logic [NUM_REQ-1:0][SPIN_W-1:0]    req_spin_i,
  output logic [NUM_REQ-1:0]                req_spin_ready_o,
  output logic [NUM_REQ-1:0]                req_energy_valid_o,
  output logic [ENERGY_W-1:0]               req_energy_o,
  input  logic [NUM_REQ-1:0]                req_energy_ready_i,
  output logic                              em_spin_valid_o,
  output logic [SPIN_W-1:0]                 em_spin_o,
  input  logic                              em_spin_ready_i,
  input  logic                              em_energy_valid_i,
  input  logic [ENERGY_W-1:0]               em_energy_i,
  output logic                              em_energy_ready_o,
  output logic                              busy_o,
  output logic [IDX_W-1:0]                  grant_idx_o,
  output logic [15:0]                       job_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETURN} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
  logic [ENERGY_W-1:0] energy_q, energy_d;
  logic [15:0]         job_cnt_q, job_cnt_d;

  logic [IDX_W-1:0]    win_idx;
  logic                win_found;

  // Cyclic search starting at rr_ptr; the first valid requester wins.
  always_comb begin : arb
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    win_idx   = rr_ptr_q;
    win_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_found && req_spin_valid_i[cand_idx]) begin
        win_idx   = cand_idx;
        win_found = 1'b1;
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d            = state_q;
    rr_ptr_d           = rr_ptr_q;
    grant_idx_d        = grant_idx_q;
    energy_d           = energy_q;
    job_cnt_d          = job_cnt_q;
    req_spin_ready_o   = '0;
    req_energy_valid_o = '0;
    em_spin_valid_o    = 1'b0;
    em_energy_ready_o  = 1'b0;

    // With en_i low nothing below runs: state holds and handshakes stay 0.
    if (en_i) begin
      unique case (state_q)
        S_IDLE: begin
          if (win_found) begin
            grant_idx_d = win_idx;
            state_d     = S_ISSUE;
          end
        end
        S_ISSUE: begin
          em_spin_valid_o               = req_spin_valid_i[grant_idx_q];
          req_spin_ready_o[grant_idx_q] = em_spin_ready_i;
          if (req_spin_valid_i[grant_idx_q] && em_spin_ready_i) state_d = S_WAIT;
        end
        S_WAIT: begin
          em_energy_ready_o = 1'b1;
          if (em_energy_valid_i) begin
            energy_d = em_energy_i;
            state_d  = S_RETURN;
          end
        end
        S_RETURN: begin
          req_energy_valid_o[grant_idx_q] = 1'b1;
          if (req_energy_ready_i[grant_idx_q]) begin
            state_d   = S_IDLE;
            rr_ptr_d  = (int'(grant_idx_q) == NUM_REQ - 1) ? '0 : grant_idx_q + 1'b1;
            job_cnt_d = job_cnt_q + 16'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: non-blocking assignments here so every flop samples the pre-edge
  // value of every other flop, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      energy_q    <= '0;
      job_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      energy_q    <= energy_d;
      job_cnt_q   <= job_cnt_d;
    end
  end

  assign em_spin_o    = req_spin_i[grant_idx_q];
  assign req_energy_o = energy_q;
  assign busy_o       = (state_q != S_IDLE);
  assign grant_idx_o  = grant_idx_q;
  assign job_cnt_o    = job_cnt_q;

endmodule

// File: tb/tb_em_job_arbiter.sv
// Self-checking bench for em_job_arbiter: scenario tasks drive the monitor and
// requesters; expected grant/energy pairs go through a scoreboard queue.
module tb_em_job_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int SPIN_W   = 256;
  localparam int ENERGY_W = 32;
  localparam int IDX_W    = 2;

  logic                           clk_i = 1'b0;
  logic                           rst_ni;
  logic                           en_i;
  logic [NUM_REQ-1:0]             req_spin_valid_i;
  logic [NUM_REQ-1:0][SPIN_W-1:0] req_spin_i;
  logic [NUM_REQ-1:0]             req_spin_ready_o;
  logic [NUM_REQ-1:0]             req_energy_valid_o;
  logic [ENERGY_W-1:0]            req_energy_o;
  logic [NUM_REQ-1:0]             req_energy_ready_i;
  logic                           em_spin_valid_o;
  logic [SPIN_W-1:0]              em_spin_o;
  logic                           em_spin_ready_i;
  logic                           em_energy_valid_i;
  logic [ENERGY_W-1:0]            em_energy_i;
  logic                           em_energy_ready_o;
  logic                           busy_o;
  logic [IDX_W-1:0]               grant_idx_o;
  logic [15:0]                    job_cnt_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [IDX_W-1:0]    idx;
    logic [ENERGY_W-1:0] energy;
  } sb_t;
  sb_t sb_q[$];

  em_job_arbiter #(.NUM_REQ(NUM_REQ), .SPIN_W(SPIN_W), .ENERGY_W(ENERGY_W)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .en_i               (en_i),
    .req_spin_valid_i   (req_spin_valid_i),
    .req_spin_i         (req_spin_i),
    .req_spin_ready_o   (req_spin_ready_o),
    .req_energy_valid_o (req_energy_valid_o),
    .req_energy_o       (req_energy_o),
    .req_energy_ready_i (req_energy_ready_i),
    .em_spin_valid_o    (em_spin_valid_o),
    .em_spin_o          (em_spin_o),
    .em_spin_ready_i    (em_spin_ready_i),
    .em_energy_valid_i  (em_energy_valid_i),
    .em_energy_i        (em_energy_i),
    .em_energy_ready_o  (em_energy_ready_o),
    .busy_o             (busy_o),
    .grant_idx_o        (grant_idx_o),
    .job_cnt_o          (job_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [SPIN_W-1:0] spin_pat(input int r);
    spin_pat = {{7{32'hC0DE_0000 + 32'(r)}}, 32'(r + 1) * 32'h0101_0101};
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int r);
    onehot    = '0;
    onehot[r] = 1'b1;
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
  endtask

  // Holds reset for two cycles, checks the reset state, releases at a negedge.
  task automatic test_reset();
    rst_ni             = 1'b0;
    en_i               = 1'b1;
    req_spin_valid_i   = '0;
    req_energy_ready_i = '0;
    em_spin_ready_i    = 1'b0;
    em_energy_valid_i  = 1'b0;
    em_energy_i        = '0;
    sb_q.delete();
    cyc(2);
    total++;
    if (busy_o !== 1'b0 || grant_idx_o !== '0 || job_cnt_o !== 16'h0 || req_energy_o !== '0) begin
      bad++;
      $display("FAIL reset_state: busy=%b grant=%0d cnt=%h energy=%h, want 0 0 0 0",
               busy_o, grant_idx_o, job_cnt_o, req_energy_o);
    end
    total++;
    if ({req_spin_ready_o, req_energy_valid_o, em_spin_valid_o, em_energy_ready_o} !== '0) begin
      bad++;
      $display("FAIL reset_handshakes: got %b want all 0",
               {req_spin_ready_o, req_energy_valid_o, em_spin_valid_o, em_energy_ready_o});
    end
    rst_ni = 1'b1;
  endtask

  // Runs one job from an IDLE negedge with requests already driven.
  task automatic do_job(input int exp_idx, input int spin_lat, input int comp_lat,
                        input int ret_lat, input logic [ENERGY_W-1:0] energy, input bit drop_req);
    logic [15:0] cnt_before;
    sb_t         exp_e;
    int          n;
    cnt_before = job_cnt_o;
    cyc();
    total++;
    if (grant_idx_o !== IDX_W'(exp_idx) || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL grant: got idx=%0d busy=%b want idx=%0d busy=1", grant_idx_o, busy_o, exp_idx);
    end
    repeat (spin_lat) begin
      total++;
      if (em_spin_valid_o !== 1'b1 || req_spin_ready_o !== '0 || grant_idx_o !== IDX_W'(exp_idx)) begin
        bad++;
        $display("FAIL spin_hold: valid=%b ready=%b grant=%0d want 1 0000 %0d",
                 em_spin_valid_o, req_spin_ready_o, grant_idx_o, exp_idx);
      end
      cyc();
    end
    total++;
    if (em_spin_o !== spin_pat(exp_idx)) begin
      bad++;
      $display("FAIL em_spin: got %h want %h", em_spin_o, spin_pat(exp_idx));
    end
    em_spin_ready_i = 1'b1;
    #1;
    total++;
    if (req_spin_ready_o !== onehot(exp_idx) || em_spin_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL spin_ready: ready=%b valid=%b want %b 1",
               req_spin_ready_o, em_spin_valid_o, onehot(exp_idx));
    end
    cyc();
    em_spin_ready_i = 1'b0;
    if (drop_req) req_spin_valid_i[exp_idx] = 1'b0;
    total++;
    if (em_energy_ready_o !== 1'b1 || em_spin_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL wait_state: energy_ready=%b spin_valid=%b want 1 0",
               em_energy_ready_o, em_spin_valid_o);
    end
    cyc(comp_lat);
    em_energy_valid_i = 1'b1;
    em_energy_i       = energy;
    sb_q.push_back('{idx: IDX_W'(exp_idx), energy: energy});
    cyc();
    em_energy_valid_i = 1'b0;
    em_energy_i       = ~energy;
    n = 0;
    while (req_energy_valid_o === '0 && n < 20) begin
      cyc();
      n++;
    end
    if (req_energy_valid_o === '0) begin
      total++;
      bad++;
      $display("FAIL return_timeout: no energy valid within 20 cycles for req %0d", exp_idx);
      return;
    end
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: energy valid %b with nothing expected", req_energy_valid_o);
      return;
    end
    exp_e = sb_q.pop_front();
    if (req_energy_valid_o !== onehot(int'(exp_e.idx)) || req_energy_o !== exp_e.energy ||
        n != 0 || em_energy_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL return: valid=%b energy=%h delay=%0d ready=%b want %b %h 0 0",
               req_energy_valid_o, req_energy_o, n, em_energy_ready_o,
               onehot(int'(exp_e.idx)), exp_e.energy);
    end
    repeat (ret_lat) begin
      req_energy_ready_i = ~onehot(exp_idx);
      cyc();
      total++;
      if (req_energy_valid_o !== onehot(exp_idx) || req_energy_o !== energy ||
          job_cnt_o !== cnt_before) begin
        bad++;
        $display("FAIL return_hold: valid=%b energy=%h cnt=%h want %b %h %h",
                 req_energy_valid_o, req_energy_o, job_cnt_o, onehot(exp_idx), energy, cnt_before);
      end
    end
    req_energy_ready_i = onehot(exp_idx);
    cyc();
    req_energy_ready_i = '0;
    total++;
    if (busy_o !== 1'b0 || job_cnt_o !== 16'(cnt_before + 16'd1) || req_energy_valid_o !== '0) begin
      bad++;
      $display("FAIL job_done: busy=%b cnt=%h valid=%b want 0 %h 0000",
               busy_o, job_cnt_o, req_energy_valid_o, 16'(cnt_before + 16'd1));
    end
  endtask

  task automatic test_single_job();
    test_reset();
    req_spin_valid_i[2] = 1'b1;
    do_job(2, 0, 3, 0, 32'h0000_1234, 1'b1);
  endtask

  task automatic test_fairness();
    int order[6] = '{0, 1, 2, 3, 0, 1};
    test_reset();
    req_spin_valid_i = '1;
    foreach (order[i]) begin
      if (i == 5) req_spin_valid_i = '0;
      if (i == 5) req_spin_valid_i[order[i]] = 1'b1;
      do_job(order[i], i % 2, i, 0, 32'hA000_0000 + 32'(i), 1'b0);
    end
    req_spin_valid_i = '0;
    total++;
    if (job_cnt_o !== 16'd6) begin
      bad++;
      $display("FAIL fairness_count: got %0d want 6", job_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    test_reset();
    req_spin_valid_i[1] = 1'b1;
    req_spin_valid_i[3] = 1'b1;
    do_job(1, 5, 2, 3, 32'hFEED_0001, 1'b1);
    total++;
    if (job_cnt_o !== 16'd1) begin
      bad++;
      $display("FAIL backpressure_count: got %0d want 1", job_cnt_o);
    end
    do_job(3, 0, 0, 0, 32'hFEED_0003, 1'b1);
  endtask

  // Drops en_i for four cycles with every handshake input asserted.
  task automatic gate_enable(input string tag, input logic [15:0] cnt);
    en_i               = 1'b0;
    em_spin_ready_i    = 1'b1;
    em_energy_valid_i  = 1'b1;
    em_energy_i        = 32'hDEAD_BEEF;
    req_energy_ready_i = '1;
    #1;
    repeat (4) begin
      total++;
      if ({req_spin_ready_o, req_energy_valid_o, em_spin_valid_o, em_energy_ready_o} !== '0 ||
          busy_o !== 1'b1 || job_cnt_o !== cnt || grant_idx_o !== '0) begin
        bad++;
        $display("FAIL enable_gate_%s: hs=%b busy=%b cnt=%h grant=%0d want 0 1 %h 0", tag,
                 {req_spin_ready_o, req_energy_valid_o, em_spin_valid_o, em_energy_ready_o},
                 busy_o, job_cnt_o, cnt, grant_idx_o);
      end
      cyc();
    end
    en_i               = 1'b1;
    em_spin_ready_i    = 1'b0;
    em_energy_valid_i  = 1'b0;
    em_energy_i        = '0;
    req_energy_ready_i = '0;
    #1;
  endtask

  task automatic test_enable();
    sb_t exp_e;
    test_reset();
    req_spin_valid_i[0] = 1'b1;
    cyc();
    gate_enable("issue", 16'd0);
    total++;
    if (em_spin_valid_o !== 1'b1 || em_spin_o !== spin_pat(0)) begin
      bad++;
      $display("FAIL enable_issue_resume: valid=%b want 1", em_spin_valid_o);
    end
    em_spin_ready_i = 1'b1;
    cyc();
    em_spin_ready_i     = 1'b0;
    req_spin_valid_i[0] = 1'b0;
    gate_enable("wait", 16'd0);
    total++;
    if (em_energy_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL enable_wait_resume: energy_ready=%b want 1", em_energy_ready_o);
    end
    em_energy_valid_i = 1'b1;
    em_energy_i       = 32'h0000_5A5A;
    sb_q.push_back('{idx: 2'd0, energy: 32'h0000_5A5A});
    cyc();
    em_energy_valid_i = 1'b0;
    gate_enable("return", 16'd0);
    exp_e = sb_q.pop_front();
    total++;
    if (req_energy_valid_o !== onehot(int'(exp_e.idx)) || req_energy_o !== exp_e.energy) begin
      bad++;
      $display("FAIL enable_return: valid=%b energy=%h want %b %h",
               req_energy_valid_o, req_energy_o, onehot(int'(exp_e.idx)), exp_e.energy);
    end
    req_energy_ready_i[0] = 1'b1;
    cyc();
    req_energy_ready_i = '0;
    total++;
    if (busy_o !== 1'b0 || job_cnt_o !== 16'd1) begin
      bad++;
      $display("FAIL enable_done: busy=%b cnt=%0d want 0 1", busy_o, job_cnt_o);
    end
  endtask

  task automatic test_reset_mid_job();
    req_spin_valid_i[2] = 1'b1;
    cyc();
    em_spin_ready_i = 1'b1;
    cyc();
    em_spin_ready_i     = 1'b0;
    req_spin_valid_i[2] = 1'b0;
    total++;
    if (em_energy_ready_o !== 1'b1 || job_cnt_o === 16'd0) begin
      bad++;
      $display("FAIL midjob_setup: energy_ready=%b cnt=%0d want 1 nonzero", em_energy_ready_o, job_cnt_o);
    end
    rst_ni = 1'b0;
    #1;
    total++;
    if (busy_o !== 1'b0 || job_cnt_o !== 16'd0 || grant_idx_o !== '0 || em_energy_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: busy=%b cnt=%0d grant=%0d ready=%b want 0 0 0 0",
               busy_o, job_cnt_o, grant_idx_o, em_energy_ready_o);
    end
    cyc();
    rst_ni = 1'b1;
    req_spin_valid_i[3] = 1'b1;
    do_job(3, 0, 1, 0, 32'h3333_0003, 1'b1);
  endtask

  task automatic test_counter_wrap();
    force dut.job_cnt_q = 16'hFFFF;
    cyc();
    release dut.job_cnt_q;
    #1;
    total++;
    if (job_cnt_o !== 16'hFFFF) begin
      bad++;
      $display("FAIL wrap_preload: got %h want ffff", job_cnt_o);
    end
    req_spin_valid_i[1] = 1'b1;
    do_job(1, 0, 0, 0, 32'h0BAD_F00D, 1'b1);
    total++;
    if (job_cnt_o !== 16'h0000) begin
      bad++;
      $display("FAIL wrap: got %h want 0000", job_cnt_o);
    end
  endtask

  initial begin
    rst_ni             = 1'b0;
    en_i               = 1'b1;
    req_spin_valid_i   = '0;
    req_energy_ready_i = '0;
    em_spin_ready_i    = 1'b0;
    em_energy_valid_i  = 1'b0;
    em_energy_i        = '0;
    for (int r = 0; r < NUM_REQ; r++) req_spin_i[r] = spin_pat(r);

    test_reset();
    test_single_job();
    test_fairness();
    test_back_to_back();
    test_enable();
    test_reset_mid_job();
    test_counter_wrap();

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: %0d entries, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
